// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO slice.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_AF_THRESH  = 14;
  localparam int DEF_AE_THRESH  = 2;

  // One extra wrap bit distinguishes full from empty when addresses match.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  clr_err;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wdata, rd_en, clr_err,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en, clr_err,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Flop-array storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input logic       wclk,
  input logic       wrst,
  sync_fifo_if.slave bus
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_CNT = PW'(2**ADDR_WIDTH);
  localparam logic [PW-1:0] AF_CNT    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_CNT    = PW'(AE_THRESH);

  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= 2**ADDR_WIDTH)) begin : g_param_chk
    $error("sync_fifo: thresholds must satisfy AE_THRESH < AF_THRESH <= 2**ADDR_WIDTH");
  end

  logic [PW-1:0]         wptr, rptr, count;
  logic [PW-1:0]         wptr_n, rptr_n, count_n;
  logic                  full, empty, almost_full, almost_empty;
  logic                  overflow, underflow;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    wr_acc  = bus.wr_en & ~full;
    rd_acc  = bus.rd_en & ~empty;
    wptr_n  = wr_acc ? wptr + PW'(1) : wptr;
    rptr_n  = rd_acc ? rptr + PW'(1) : rptr;
    count_n = wptr_n - rptr_n;
  end

  // Flags are registered from next-state count so they always match count.
  always_ff @(posedge wclk) begin
    if (!wrst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      count        <= count_n;
      full         <= (count_n == DEPTH_CNT);
      empty        <= (count_n == '0);
      almost_full  <= (count_n >= AF_CNT);
      almost_empty <= (count_n <= AE_CNT);
      // A new error on the same edge as clr_err keeps the flag set.
      overflow     <= (bus.wr_en & full)  | (overflow  & ~bus.clr_err);
      underflow    <= (bus.rd_en & empty) | (underflow & ~bus.clr_err);
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (wclk),
    .we    (wr_acc & wrst),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (bus.wdata),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible combinationally; masked to zero while empty.
  assign bus.rdata = empty ? '0 : ram_rdata;
`else
  // Stage p1: read data registered on the accepting edge, held otherwise.
  logic [DATA_WIDTH-1:0] rdata_p1;

  always_ff @(posedge wclk) begin
    if (!wrst)       rdata_p1 <= '0;
    else if (rd_acc) rdata_p1 <= ram_rdata;
  end

  assign bus.rdata = rdata_p1;
`endif

  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = almost_full;
  assign bus.almost_empty = almost_empty;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter AF_THRESH, default 14: almost_full asserts when count >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost_empty asserts when count <= AE_THRESH.
REQ-005 SHALL have port wclk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port wrst  in  1  reset; synchronous, active-low.
REQ-007 SHALL have port wr_en  in  1  write request.
REQ-008 SHALL have port wdata  in  DATA_WIDTH  write data.
REQ-009 SHALL have port rd_en  in  1  read request.
REQ-010 SHALL have port rdata  out  DATA_WIDTH  read data.
REQ-011 SHALL have port clr_err  in  1  clears sticky error flags.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-013 SHALL have port count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
REQ-014 SHALL have ports overflow, underflow  out  1 each  sticky error flags.

Function
REQ-015 A write SHALL be accepted iff wr_en=1 and full=0; data stored at wptr, wptr+1.
REQ-016 A read SHALL be accepted iff rd_en=1 and empty=0; rptr+1.
REQ-017 Pointers SHALL be ADDR_WIDTH+1 bits, wrapping modulo 2**(ADDR_WIDTH+1); MSB is the wrap bit.
REQ-018 count SHALL equal wptr-rptr modulo 2**(ADDR_WIDTH+1), registered, updated in the edge that accepts the access.
REQ-019 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-020 full SHALL be 1 iff count == 2**ADDR_WIDTH; empty SHALL be 1 iff count == 0; all four flags registered and consistent with count in the same cycle.
REQ-021 When full, wr_en with rd_en SHALL accept the read only; the write is dropped.
REQ-022 When empty, rd_en with wr_en SHALL accept the write only; no read bypass.
REQ-023 overflow SHALL set on any edge with wr_en=1 and full=1; underflow SHALL set on any edge with rd_en=1 and empty=1.
REQ-024 Error flags SHALL hold until clr_err=1; if set and clear coincide, set wins.
REQ-025 Rejected accesses SHALL NOT change pointers, count, memory or rdata.
REQ-026 Standard mode: rdata SHALL be registered, carrying the read word one cycle after the accepting edge, and holding its value otherwise.

Reset
REQ-027 wrst=0 at a rising edge SHALL set wptr=rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0, rdata=0.
REQ-028 Reset mid-operation SHALL discard all contents; memory array is not cleared; reset overrides every simultaneous access.

Configuration
REQ-029 Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; rdata SHALL show the word at rptr whenever empty=0 (0 latency); rd_en acknowledges and advances.
REQ-030 Macro undefined: standard mode per REQ-026.
REQ-031 Parameters SHALL satisfy AE_THRESH < AF_THRESH <= 2**ADDR_WIDTH; violation reported by elaboration-time error.

Structure
REQ-032 Package fifo_pkg SHALL hold default width/depth constants and the pointer-width function (ADDR_WIDTH+1).
REQ-033 Storage SHALL be sub-module fifo_ram: flop array, one write port, one asynchronous read port.

Verification (defaults: DATA_WIDTH=8, ADDR_WIDTH=4)
REQ-034 Reset, then 16 writes 0x00..0x0F -> full=1, count=16, almost_full=1 from count 14; 17th write -> overflow=1, contents unchanged.
REQ-035 16 reads after REQ-034 -> rdata 0x00..0x0F in order (1-cycle latency standard, 0 in FWFT); empty=1; extra rd_en -> underflow=1.
REQ-036 Count=8, simultaneous wr/rd for 20 cycles -> count stays 8; pointers wrap; data order preserved.
REQ-037 Full plus wr_en and rd_en -> read accepted, count=15, overflow=1; empty plus both -> count=1, underflow=1.
REQ-038 Error flag set, then clr_err for 1 cycle -> flag 0; clr_err coinciding with new error -> flag stays 1.
REQ-039 wrst=0 at count=10 -> next cycle count=0, empty=1, all flags at reset values; next write/read returns the new data.
